cmd_arb: RTL and testbench
==========================

CMD_ARB -- requirements
Module: cmd_arb

Interface
REQ-001 Parameter TO_CYC, default 1024: max cycles in ISSUE waiting for clr_cmd_rdy before abort.
REQ-002 Parameter TOUR_MOVES, default 24: number of tour-sourced commands that ends tour mode.
REQ-003 clk  input  1  system clock; the only clock, all state on rising edge.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 cmd_UART  input  16  command from UART wrapper.
REQ-006 cmd_rdy_UART  input  1  UART command valid; level, held until cleared.
REQ-007 clr_cmd_rdy_UART  output  1  one-cycle pulse consuming the UART command.
REQ-008 cmd_TC  input  16  command from tour-command generator.
REQ-009 cmd_rdy_TC  input  1  tour command valid; level, held until cleared.
REQ-010 clr_cmd_rdy_TC  output  1  one-cycle pulse consuming the tour command.
REQ-011 start_tour  input  1  one-cycle pulse from cmd_proc; enters tour mode.
REQ-012 cmd  output  16  granted command to cmd_proc.
REQ-013 cmd_rdy  output  1  granted command valid to cmd_proc.
REQ-014 clr_cmd_rdy  input  1  cmd_proc has accepted cmd.
REQ-015 send_resp  input  1  cmd_proc finished the command.
REQ-016 send_resp_UART  output  1  one-cycle pulse: UART wrapper sends ack 8'hA5.
REQ-017 send_resp_TC  output  1  one-cycle pulse: tour generator may issue next move.
REQ-018 tour_mode  output  1  tour mode active.
REQ-019 to_err  output  1  one-cycle pulse on ISSUE timeout.

Function
REQ-020 FSM states SHALL be IDLE, ISSUE, EXEC, RESP; owner register src (UART/TC) latched on grant.
REQ-021 IDLE: tour_mode=0 -> UART wins; tour_mode=1 -> TC wins; losing request SHALL stay pending, never cleared.
REQ-022 On grant (IDLE->ISSUE) the block SHALL latch the source command into cmd and pulse that source's clr_cmd_rdy_* in the same edge.
REQ-023 cmd_rdy SHALL be 1 exactly while in ISSUE; first valid cycle is the cycle after the request is sampled in IDLE (latency 1).
REQ-024 ISSUE: clr_cmd_rdy -> EXEC; timeout counter reaching TO_CYC-1 without clr_cmd_rdy -> IDLE with to_err pulse, no response pulse.
REQ-025 EXEC: wait unbounded for send_resp -> RESP; clr_cmd_rdy in EXEC ignored.
REQ-026 RESP: one cycle; pulse send_resp_UART if src=UART else send_resp_TC; then IDLE.
REQ-027 send_resp outside EXEC SHALL be ignored.
REQ-028 start_tour sets tour_mode and clears move counter mv_cnt (5 bits); start_tour while tour_mode=1 restarts the count.
REQ-029 mv_cnt SHALL increment in RESP when src=TC; reaching TOUR_MOVES clears tour_mode in the same edge.
REQ-030 cmd SHALL hold its value outside ISSUE until next grant; timeout counter clears on every ISSUE entry.

Reset
REQ-031 Reset SHALL force IDLE, src=UART, cmd=16'h0000, cmd_rdy=0, all pulse outputs 0, tour_mode=0, mv_cnt=0, timeout counter=0.
REQ-032 Reset mid-command SHALL abort without any response pulse; pending source requests are not cleared.

Structure
REQ-033 State enum, src enum, ACK value 8'hA5 and opcode constants SHALL live in the shared project package.
REQ-034 The timeout counter SHALL be a sub-module cmd_arb_tmr (clear, enable, expired).

Verification
REQ-035 UART 16'h47F1 only: cmd_rdy next cycle, cmd=16'h47F1; clr_cmd_rdy then send_resp -> one send_resp_UART pulse, no send_resp_TC.
REQ-036 cmd_rdy_UART and cmd_rdy_TC same cycle, tour_mode=0 -> UART granted, TC held; after RESP TC granted next.
REQ-037 start_tour, then both ready -> TC granted, UART pending; after 24 TC completions tour_mode=0 and UART granted.
REQ-038 Grant with no clr_cmd_rdy for 1024 cycles -> to_err pulse, back to IDLE, cmd_rdy=0, no response pulses.
REQ-039 rst_n low during EXEC -> all outputs at reset values immediately, later send_resp produces no pulse.

Source files
------------

// File: rtl/cmd_arb_pkg.sv
// Shared types and constants for the command arbiter between the UART and tour-command sources.
package cmd_arb_pkg;

    localparam int unsigned CMD_W = 16;
    localparam int unsigned MV_W  = 5;

    localparam logic [7:0] ACK = 8'hA5;

    localparam logic [3:0] OP_CAL  = 4'b0000;
    localparam logic [3:0] OP_HDG  = 4'b0010;
    localparam logic [3:0] OP_MOVE = 4'b0100;
    localparam logic [3:0] OP_FAN  = 4'b0101;
    localparam logic [3:0] OP_TOUR = 4'b0110;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        EXEC  = 2'd2,
        RESP  = 2'd3
    } arb_state_t;

    typedef enum logic {
        SRC_UART = 1'b0,
        SRC_TC   = 1'b1
    } arb_src_t;

    typedef struct packed {
        logic [3:0]  opcode;
        logic [11:0] arg;
    } cmd_t;

endpackage

// File: rtl/cmd_arb_if.sv
// Handshake bundle between the two command sources, the arbiter and cmd_proc.
interface cmd_arb_if;
    import cmd_arb_pkg::*;

    logic [CMD_W-1:0] cmd_UART;
    logic             cmd_rdy_UART;
    logic             clr_cmd_rdy_UART;
    logic [CMD_W-1:0] cmd_TC;
    logic             cmd_rdy_TC;
    logic             clr_cmd_rdy_TC;
    logic             start_tour;
    logic [CMD_W-1:0] cmd;
    logic             cmd_rdy;
    logic             clr_cmd_rdy;
    logic             send_resp;
    logic             send_resp_UART;
    logic             send_resp_TC;
    logic             tour_mode;
    logic             to_err;

    modport master (
        input  cmd_UART, cmd_rdy_UART, cmd_TC, cmd_rdy_TC, start_tour,
               clr_cmd_rdy, send_resp,
        output clr_cmd_rdy_UART, clr_cmd_rdy_TC, cmd, cmd_rdy,
               send_resp_UART, send_resp_TC, tour_mode, to_err
    );

    modport slave (
        output cmd_UART, cmd_rdy_UART, cmd_TC, cmd_rdy_TC, start_tour,
               clr_cmd_rdy, send_resp,
        input  clr_cmd_rdy_UART, clr_cmd_rdy_TC, cmd, cmd_rdy,
               send_resp_UART, send_resp_TC, tour_mode, to_err
    );

endinterface

// File: rtl/cmd_arb_tmr.sv
// ISSUE wait counter: cleared on entry, counts while enabled, flags the last allowed cycle.
module cmd_arb_tmr #(
    parameter int unsigned TO_CYC = 1024
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam int unsigned CW = (TO_CYC > 1) ? $clog2(TO_CYC) : 1;
    localparam logic [CW-1:0] LAST = CW'(TO_CYC - 1);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;
    logic          expired_d;

    // expired is kept registered but always equals (cnt_q == LAST)
    always_comb begin
        cnt_d = cnt_q;
        if (clear) begin
            cnt_d = '0;
        end else if (enable) begin
            cnt_d = cnt_q + CW'(1);
        end
        expired_d = (cnt_d == LAST);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q   <= '0;
            expired <= (LAST == '0);
        end else begin
            cnt_q   <= cnt_d;
            expired <= expired_d;
        end
    end

endmodule

// File: rtl/cmd_arb.sv
// Arbitrates UART and tour-generator commands into cmd_proc and routes the response back to the owner.
module cmd_arb
    import cmd_arb_pkg::*;
#(
    parameter int unsigned TO_CYC     = 1024,
    parameter int unsigned TOUR_MOVES = 24
) (
    input  logic      clk,
    input  logic      rst_n,
    cmd_arb_if.master bus
);

    arb_state_t      state_q, state_d;
    arb_src_t        src_q, src_d;
    cmd_t            cmd_q, cmd_d;
    logic            cmd_rdy_q, cmd_rdy_d;
    logic            clr_uart_q, clr_uart_d;
    logic            clr_tc_q, clr_tc_d;
    logic            resp_uart_q, resp_uart_d;
    logic            resp_tc_q, resp_tc_d;
    logic            to_err_q, to_err_d;
    logic            tour_q, tour_d;
    logic [MV_W-1:0] mv_cnt_q, mv_cnt_d;
    logic            grant_tc;
    logic            tmr_clear;
    logic            tmr_enable;
    logic            tmr_expired;

    cmd_arb_tmr #(.TO_CYC(TO_CYC)) u_tmr (
        .clk     (clk),
        .rst_n   (rst_n),
        .clear   (tmr_clear),
        .enable  (tmr_enable),
        .expired (tmr_expired)
    );

    // Next-state and next-output logic; pulses default low every cycle
    always_comb begin
        state_d     = state_q;
        src_d       = src_q;
        cmd_d       = cmd_q;
        cmd_rdy_d   = 1'b0;
        clr_uart_d  = 1'b0;
        clr_tc_d    = 1'b0;
        resp_uart_d = 1'b0;
        resp_tc_d   = 1'b0;
        to_err_d    = 1'b0;
        tour_d      = tour_q;
        mv_cnt_d    = mv_cnt_q;
        tmr_clear   = 1'b0;
        tmr_enable  = 1'b0;
        grant_tc    = bus.cmd_rdy_TC && (tour_q || !bus.cmd_rdy_UART);

        case (state_q)
            IDLE: begin
                if (bus.cmd_rdy_UART || bus.cmd_rdy_TC) begin
                    state_d   = ISSUE;
                    cmd_rdy_d = 1'b1;
                    tmr_clear = 1'b1;
                    if (grant_tc) begin
                        src_d    = SRC_TC;
                        cmd_d    = cmd_t'(bus.cmd_TC);
                        clr_tc_d = 1'b1;
                    end else begin
                        src_d      = SRC_UART;
                        cmd_d      = cmd_t'(bus.cmd_UART);
                        clr_uart_d = 1'b1;
                    end
                end
            end
            ISSUE: begin
                tmr_enable = 1'b1;
                if (bus.clr_cmd_rdy) begin
                    state_d = EXEC;
                end else if (tmr_expired) begin
                    state_d  = IDLE;
                    to_err_d = 1'b1;
                end else begin
                    cmd_rdy_d = 1'b1;
                end
            end
            EXEC: begin
                if (bus.send_resp) begin
                    state_d     = RESP;
                    resp_uart_d = (src_q == SRC_UART);
                    resp_tc_d   = (src_q == SRC_TC);
                end
            end
            RESP: begin
                state_d = IDLE;
                if (src_q == SRC_TC) begin
                    mv_cnt_d = mv_cnt_q + MV_W'(1);
                    if (mv_cnt_d == MV_W'(TOUR_MOVES)) begin
                        tour_d = 1'b0;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        // A fresh start_tour always wins over a move-count update in the same cycle
        if (bus.start_tour) begin
            tour_d   = 1'b1;
            mv_cnt_d = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            src_q       <= SRC_UART;
            cmd_q       <= '0;
            cmd_rdy_q   <= 1'b0;
            clr_uart_q  <= 1'b0;
            clr_tc_q    <= 1'b0;
            resp_uart_q <= 1'b0;
            resp_tc_q   <= 1'b0;
            to_err_q    <= 1'b0;
            tour_q      <= 1'b0;
            mv_cnt_q    <= '0;
        end else begin
            state_q     <= state_d;
            src_q       <= src_d;
            cmd_q       <= cmd_d;
            cmd_rdy_q   <= cmd_rdy_d;
            clr_uart_q  <= clr_uart_d;
            clr_tc_q    <= clr_tc_d;
            resp_uart_q <= resp_uart_d;
            resp_tc_q   <= resp_tc_d;
            to_err_q    <= to_err_d;
            tour_q      <= tour_d;
            mv_cnt_q    <= mv_cnt_d;
        end
    end

    assign bus.cmd              = cmd_q;
    assign bus.cmd_rdy          = cmd_rdy_q;
    assign bus.clr_cmd_rdy_UART = clr_uart_q;
    assign bus.clr_cmd_rdy_TC   = clr_tc_q;
    assign bus.send_resp_UART   = resp_uart_q;
    assign bus.send_resp_TC     = resp_tc_q;
    assign bus.tour_mode        = tour_q;
    assign bus.to_err           = to_err_q;

endmodule

// File: tb/tb_cmd_arb.sv
// Directed bench for cmd_arb with a transaction-level reference model checked every cycle.
module tb_cmd_arb;

    localparam int TO_CYC     = 1024;
    localparam int TOUR_MOVES = 24;

    logic clk = 1'b0;
    logic rst_n;

    always #5 clk = ~clk;

    cmd_arb_if bus();

    cmd_arb #(.TO_CYC(TO_CYC), .TOUR_MOVES(TOUR_MOVES)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int n_cmp = 0;
    int n_err = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge clk);
        #1;
    endtask

    // Command sources: present queued commands, drop ready when consumed
    logic [15:0] uart_q[$];
    logic [15:0] tc_q[$];

    initial begin
        bus.cmd_UART     = '0;
        bus.cmd_rdy_UART = 1'b0;
        forever begin
            @(negedge clk);
            if (bus.clr_cmd_rdy_UART) bus.cmd_rdy_UART = 1'b0;
            else if (!bus.cmd_rdy_UART && uart_q.size() > 0) begin
                bus.cmd_UART     = uart_q.pop_front();
                bus.cmd_rdy_UART = 1'b1;
            end
        end
    end

    initial begin
        bus.cmd_TC     = '0;
        bus.cmd_rdy_TC = 1'b0;
        forever begin
            @(negedge clk);
            if (bus.clr_cmd_rdy_TC) bus.cmd_rdy_TC = 1'b0;
            else if (!bus.cmd_rdy_TC && tc_q.size() > 0) begin
                bus.cmd_TC     = tc_q.pop_front();
                bus.cmd_rdy_TC = 1'b1;
            end
        end
    end

    // Reference model: one outstanding command described by live/accepted/answered flags
    logic        m_live = 0, m_acc = 0, m_done = 0, m_tc = 0, m_tour = 0;
    int          m_age = 0, m_moves = 0;
    logic [15:0] m_cmd = '0;
    logic        e_clr_u = 0, e_clr_t = 0, e_ru = 0, e_rt = 0, e_terr = 0;

    initial begin
        forever begin
            @(posedge clk or negedge rst_n);
            e_clr_u = 0; e_clr_t = 0; e_ru = 0; e_rt = 0; e_terr = 0;
            if (!rst_n) begin
                m_live = 0; m_acc = 0; m_done = 0; m_tc = 0; m_tour = 0;
                m_age = 0; m_moves = 0; m_cmd = '0;
            end else begin
                if (!m_live) begin
                    if (bus.cmd_rdy_UART || bus.cmd_rdy_TC) begin
                        m_tc   = bus.cmd_rdy_TC && (m_tour || !bus.cmd_rdy_UART);
                        m_cmd  = m_tc ? bus.cmd_TC : bus.cmd_UART;
                        e_clr_t = m_tc;
                        e_clr_u = !m_tc;
                        m_live = 1; m_acc = 0; m_done = 0; m_age = 0;
                    end
                end else if (!m_acc) begin
                    if (bus.clr_cmd_rdy) m_acc = 1;
                    else if (m_age == TO_CYC - 1) begin
                        m_live = 0;
                        e_terr = 1;
                    end else m_age++;
                end else if (!m_done) begin
                    if (bus.send_resp) begin
                        m_done = 1;
                        e_rt = m_tc;
                        e_ru = !m_tc;
                    end
                end else begin
                    m_live = 0;
                    if (m_tc) begin
                        m_moves = (m_moves + 1) % 32;
                        if (m_moves == TOUR_MOVES) m_tour = 0;
                    end
                end
                if (bus.start_tour) begin
                    m_tour = 1;
                    m_moves = 0;
                end
            end
        end
    end

    // Per-cycle comparison of every DUT output against the model
    initial begin
        forever begin
            @(negedge clk);
            chk("cmd", 32'(bus.cmd), 32'(m_cmd));
            chk("cmd_rdy", 32'(bus.cmd_rdy), 32'(m_live && !m_acc));
            chk("clr_cmd_rdy_UART", 32'(bus.clr_cmd_rdy_UART), 32'(e_clr_u));
            chk("clr_cmd_rdy_TC", 32'(bus.clr_cmd_rdy_TC), 32'(e_clr_t));
            chk("send_resp_UART", 32'(bus.send_resp_UART), 32'(e_ru));
            chk("send_resp_TC", 32'(bus.send_resp_TC), 32'(e_rt));
            chk("tour_mode", 32'(bus.tour_mode), 32'(m_tour));
            chk("to_err", 32'(bus.to_err), 32'(e_terr));
        end
    end

    int c_ru = 0, c_rt = 0, c_ct = 0, c_te = 0;

    initial begin
        forever begin
            @(negedge clk);
            if (bus.send_resp_UART) c_ru++;
            if (bus.send_resp_TC)   c_rt++;
            if (bus.clr_cmd_rdy_TC) c_ct++;
            if (bus.to_err)         c_te++;
        end
    end

    task automatic serve(input int acc, input int rsp, output logic [15:0] got);
        int w;
        w = 0;
        while (!bus.cmd_rdy && w < 100) begin
            step(1);
            w++;
        end
        chk("grant_seen", 32'(bus.cmd_rdy), 32'd1);
        got = bus.cmd;
        repeat (acc) step(1);
        bus.clr_cmd_rdy = 1'b1;
        step(1);
        bus.clr_cmd_rdy = 1'b0;
        repeat (rsp) step(1);
        bus.send_resp = 1'b1;
        step(1);
        bus.send_resp = 1'b0;
        step(2);
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [15:0] got;
        int ru0, rt0, ct0, te0, n;
        rst_n           = 1'b0;
        bus.clr_cmd_rdy = 1'b0;
        bus.send_resp   = 1'b0;
        bus.start_tour  = 1'b0;
        step(3);
        chk("rst_cmd", 32'(bus.cmd), 32'h0);
        chk("rst_cmd_rdy", 32'(bus.cmd_rdy), 32'd0);
        chk("rst_tour", 32'(bus.tour_mode), 32'd0);
        chk("rst_to_err", 32'(bus.to_err), 32'd0);
        rst_n = 1'b1;
        step(2);

        // Single UART command, latency 1
        ru0 = c_ru; rt0 = c_rt;
        uart_q.push_back(16'h47F1);
        step(1);
        chk("t1_not_yet", 32'(bus.cmd_rdy), 32'd0);
        step(1);
        chk("t1_rdy", 32'(bus.cmd_rdy), 32'd1);
        chk("t1_cmd", 32'(bus.cmd), 32'h47F1);
        chk("t1_clr_uart", 32'(bus.clr_cmd_rdy_UART), 32'd1);
        serve(2, 3, got);
        chk("t1_got", 32'(got), 32'h47F1);
        chk("t1_resp_uart", 32'(c_ru - ru0), 32'd1);
        chk("t1_resp_tc", 32'(c_rt - rt0), 32'd0);

        // Simultaneous requests outside tour mode
        ct0 = c_ct;
        tc_q.push_back(16'h4A21);
        uart_q.push_back(16'h2C30);
        step(2);
        chk("t2_cmd_uart", 32'(bus.cmd), 32'h2C30);
        chk("t2_tc_held", 32'(bus.cmd_rdy_TC), 32'd1);
        serve(0, 0, got);
        chk("t2_first", 32'(got), 32'h2C30);
        serve(1, 1, got);
        chk("t2_second", 32'(got), 32'h4A21);
        chk("t2_clr_tc", 32'(c_ct - ct0), 32'd1);
        step(2);
        chk("t2_cmd_hold", 32'(bus.cmd), 32'h4A21);

        // Tour: TC wins for 24 moves then UART gets through
        bus.start_tour = 1'b1;
        step(1);
        bus.start_tour = 1'b0;
        chk("t3_tour_on", 32'(bus.tour_mode), 32'd1);
        ru0 = c_ru; rt0 = c_rt;
        uart_q.push_back(16'h0FFF);
        for (int i = 0; i < TOUR_MOVES + 1; i++) tc_q.push_back(16'(16'h6000 + i));
        for (int i = 0; i < TOUR_MOVES; i++) begin
            serve(1, 2, got);
            chk("t3_tour_cmd", 32'(got), 32'(16'h6000 + i));
            if (i == TOUR_MOVES - 2) chk("t3_tour_still_on", 32'(bus.tour_mode), 32'd1);
        end
        chk("t3_tour_off", 32'(bus.tour_mode), 32'd0);
        chk("t3_uart_rdy", 32'(bus.cmd_rdy), 32'd1);
        chk("t3_uart_cmd", 32'(bus.cmd), 32'h0FFF);
        chk("t3_tc_resps", 32'(c_rt - rt0), 32'(TOUR_MOVES));
        chk("t3_uart_resps", 32'(c_ru - ru0), 32'd0);
        serve(0, 0, got);
        serve(0, 0, got);
        chk("t3_tc_after", 32'(got), 32'h6018);

        // Accept on the very last allowed ISSUE cycle
        ru0 = c_ru; te0 = c_te;
        uart_q.push_back(16'h1111);
        serve(TO_CYC - 1, 0, got);
        chk("t4_edge_resp", 32'(c_ru - ru0), 32'd1);
        chk("t4_edge_no_err", 32'(c_te - te0), 32'd0);

        // Timeout with no accept
        ru0 = c_ru; rt0 = c_rt; te0 = c_te;
        uart_q.push_back(16'h3333);
        n = 0;
        while (!bus.cmd_rdy && n < 10) begin step(1); n++; end
        n = 0;
        while (bus.cmd_rdy && n < 2000) begin n++; step(1); end
        chk("t5_issue_len", 32'(n), 32'(TO_CYC));
        chk("t5_to_err", 32'(bus.to_err), 32'd1);
        chk("t5_err_count", 32'(c_te - te0), 32'd1);
        chk("t5_cmd_hold", 32'(bus.cmd), 32'h3333);
        step(1);
        chk("t5_to_err_pulse", 32'(bus.to_err), 32'd0);
        chk("t5_no_resp", 32'(c_ru - ru0 + c_rt - rt0), 32'd0);

        // Reset while executing
        bus.start_tour = 1'b1;
        step(1);
        bus.start_tour = 1'b0;
        chk("t6_tour_on", 32'(bus.tour_mode), 32'd1);
        uart_q.push_back(16'h5A5A);
        n = 0;
        while (!bus.cmd_rdy && n < 10) begin step(1); n++; end
        bus.clr_cmd_rdy = 1'b1;
        step(1);
        bus.clr_cmd_rdy = 1'b0;
        step(2);
        ru0 = c_ru; rt0 = c_rt;
        rst_n = 1'b0;
        #1;
        chk("t6_rst_cmd", 32'(bus.cmd), 32'h0);
        chk("t6_rst_rdy", 32'(bus.cmd_rdy), 32'd0);
        chk("t6_rst_tour", 32'(bus.tour_mode), 32'd0);
        chk("t6_rst_resp", 32'(bus.send_resp_UART || bus.send_resp_TC), 32'd0);
        step(2);
        rst_n = 1'b1;
        step(2);
        bus.send_resp = 1'b1;
        step(1);
        bus.send_resp = 1'b0;
        step(4);
        chk("t6_no_resp", 32'(c_ru - ru0 + c_rt - rt0), 32'd0);

        step(2);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
